// File: rtl/fdiv_sequencer.sv
// -----------------------------------------------------------------------------
// fdiv_sequencer
// Issue-side controller for the Newton-Raphson division core. It accepts packed
// IEEE-754 single/double operands, unpacks and classifies them (denormals are
// normalized), resolves special cases without the core, otherwise launches the
// core, waits its fixed latency and captures the 57-bit quotient for the rounder.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, dbl        request (accepted only when idle), 1=double 0=single
//   opa, opb          packed dividend/divisor (single uses [31:0])
//   busy, done        busy from accepted start through done; one-cycle done
//   q_sign, q_exp     result sign, signed biased exponent (pre-normalization)
//   q_fq              core quotient, 0 for special results
//   q_special, q_nan, q_inf, q_zero, q_invalid, q_dbz   special-case flags
//   core_start        one-cycle launch pulse to the core
//   core_fa, core_fb  normalized significands, hidden bit at [52]
//   core_db, core_fdiv precision, operands-valid window (ISSUE..WAIT)
//   core_fq           quotient from the core
// -----------------------------------------------------------------------------
module fdiv_sequencer #(
   parameter int unsigned CORE_LAT_D = 18,
   parameter int unsigned CORE_LAT_S = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] opa,
   input  logic [63:0] opb,
   input  logic        dbl,
   output logic        busy,
   output logic        done,
   output logic        q_sign,
   output logic [12:0] q_exp,
   output logic [56:0] q_fq,
   output logic        q_special,
   output logic        q_nan,
   output logic        q_inf,
   output logic        q_zero,
   output logic        q_invalid,
   output logic        q_dbz,
   output logic        core_start,
   output logic [52:0] core_fa,
   output logic [52:0] core_fb,
   output logic        core_db,
   output logic        core_fdiv,
   input  logic [56:0] core_fq
);

   typedef enum logic [2:0] {IDLE, UNPACK, ISSUE, WAIT, DONE} state_t;

   typedef struct packed {
      logic        sign;
      logic        zero;
      logic        inf;
      logic        nan;
      logic [52:0] sig;
      logic [12:0] eff;
   } opnd_t;

   localparam logic [7:0] LAT_D = 8'(CORE_LAT_D);
   localparam logic [7:0] LAT_S = 8'(CORE_LAT_S);

   // Leading-zero count of a 53-bit vector (53 when all zero).
   function automatic logic [5:0] lzc53(input logic [52:0] v);
      logic [5:0] n;
      n = 6'd53;
      for (int i = 0; i < 53; i++) begin
         if (v[i]) n = 6'(52 - i);
      end
      return n;
   endfunction

   // Single-precision fields are aligned onto the double layout so that one
   // datapath serves both precisions.
   function automatic opnd_t unpack_op(input logic [63:0] op, input logic dp);
      opnd_t       o;
      logic [10:0] e_fld;
      logic [51:0] frac;
      logic        emax;
      logic        ezero;
      logic        fzero;
      logic [5:0]  sh;
      o.sign = dp ? op[63] : op[31];
      e_fld  = dp ? op[62:52] : {3'b000, op[30:23]};
      frac   = dp ? op[51:0] : {op[22:0], 29'd0};
      emax   = dp ? (&op[62:52]) : (&op[30:23]);
      ezero  = (e_fld == 11'd0);
      fzero  = (frac == 52'd0);
      o.zero = ezero & fzero;
      o.inf  = emax & fzero;
      o.nan  = emax & ~fzero;
      sh     = lzc53({1'b0, frac});
      if (ezero) begin
         // Denormal: shift the leading one up to [52]; exponent becomes 1 - shift.
         o.sig = {1'b0, frac} << sh;
         o.eff = 13'd1 - {7'd0, sh};
      end else begin
         o.sig = {1'b1, frac};
         o.eff = {2'b00, e_fld};
      end
      return o;
   endfunction

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_opa;
   logic [63:0] r_opb;
   logic        r_dbl;
   logic [7:0]  r_cnt;
   logic [52:0] r_core_fa;
   logic [52:0] r_core_fb;
   logic        r_q_sign;
   logic [12:0] r_q_exp;
   logic [56:0] r_q_fq;
   logic        r_q_special;
   logic        r_q_nan;
   logic        r_q_inf;
   logic        r_q_zero;
   logic        r_q_invalid;
   logic        r_q_dbz;

   opnd_t       w_a;
   opnd_t       w_b;
   logic [12:0] w_q_exp;
   logic        w_nan_case;
   logic        w_invalid;
   logic        w_dbz;
   logic        w_inf_case;
   logic        w_zero_case;
   logic        w_special;

   // Classification and special-case priority (first match wins).
   always_comb begin
      w_a         = unpack_op(r_opa, r_dbl);
      w_b         = unpack_op(r_opb, r_dbl);
      w_q_exp     = w_a.eff - w_b.eff + (r_dbl ? 13'd1023 : 13'd127);
      w_invalid   = (w_a.zero & w_b.zero) | (w_a.inf & w_b.inf);
      w_nan_case  = w_a.nan | w_b.nan | w_invalid;
      // x/0 with x finite and nonzero; 0/0 and inf/0 are caught elsewhere.
      w_dbz       = ~w_nan_case & w_b.zero & ~w_a.inf;
      w_inf_case  = w_dbz | (~w_nan_case & w_a.inf);
      w_zero_case = ~w_nan_case & ~w_inf_case & (w_a.zero | w_b.inf);
      w_special   = w_nan_case | w_inf_case | w_zero_case;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      core_start  = 1'b0;
      core_fdiv   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_state_nxt = UNPACK;
         end
         UNPACK: begin
            busy        = 1'b1;
            w_state_nxt = w_special ? DONE : ISSUE;
         end
         ISSUE: begin
            busy        = 1'b1;
            core_start  = 1'b1;
            core_fdiv   = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            busy      = 1'b1;
            core_fdiv = 1'b1;
            if (r_cnt == 8'd1) w_state_nxt = DONE;
         end
         DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa       <= '0;
         r_opb       <= '0;
         r_dbl       <= 1'b0;
         r_cnt       <= '0;
         r_core_fa   <= '0;
         r_core_fb   <= '0;
         r_q_sign    <= 1'b0;
         r_q_exp     <= '0;
         r_q_fq      <= '0;
         r_q_special <= 1'b0;
         r_q_nan     <= 1'b0;
         r_q_inf     <= 1'b0;
         r_q_zero    <= 1'b0;
         r_q_invalid <= 1'b0;
         r_q_dbz     <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_opa <= opa;
                  r_opb <= opb;
                  r_dbl <= dbl;
               end
            end
            UNPACK: begin
               r_core_fa   <= w_a.sig;
               r_core_fb   <= w_b.sig;
               r_q_sign    <= w_nan_case ? 1'b0 : (w_a.sign ^ w_b.sign);
               r_q_exp     <= w_special ? 13'd0 : w_q_exp;
               r_q_fq      <= '0;
               r_q_special <= w_special;
               r_q_nan     <= w_nan_case;
               r_q_inf     <= w_inf_case;
               r_q_zero    <= w_zero_case;
               r_q_invalid <= w_invalid;
               r_q_dbz     <= w_dbz;
            end
            ISSUE: begin
               r_cnt <= r_dbl ? LAT_D : LAT_S;
            end
            WAIT: begin
               r_cnt <= r_cnt - 8'd1;
               // Count of 1 marks the cycle the core's quotient is valid.
               if (r_cnt == 8'd1) r_q_fq <= core_fq;
            end
            default: ;
         endcase
      end
   end

   assign core_fa   = r_core_fa;
   assign core_fb   = r_core_fb;
   assign core_db   = r_dbl;
   assign q_sign    = r_q_sign;
   assign q_exp     = r_q_exp;
   assign q_fq      = r_q_fq;
   assign q_special = r_q_special;
   assign q_nan     = r_q_nan;
   assign q_inf     = r_q_inf;
   assign q_zero    = r_q_zero;
   assign q_invalid = r_q_invalid;
   assign q_dbz     = r_q_dbz;

endmodule

// File: tb/tb_fdiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fdiv_sequencer
// Directed bench for fdiv_sequencer. A small core model returns a chosen
// quotient only in the cycle the core latency says it is valid, so latency or
// capture errors show up as a wrong q_fq.
// -----------------------------------------------------------------------------
module tb_fdiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start;
   logic [63:0] opa;
   logic [63:0] opb;
   logic        dbl;
   logic        busy;
   logic        done;
   logic        q_sign;
   logic [12:0] q_exp;
   logic [56:0] q_fq;
   logic        q_special;
   logic        q_nan;
   logic        q_inf;
   logic        q_zero;
   logic        q_invalid;
   logic        q_dbz;
   logic        core_start;
   logic [52:0] core_fa;
   logic [52:0] core_fb;
   logic        core_db;
   logic        core_fdiv;
   logic [56:0] core_fq;

   int          tests = 0;
   int          failed = 0;
   int          cyc = 0;
   int          lat_now = 0;
   int          since = 0;
   logic [56:0] fq_val = '0;
   int          cs;
   int          ncs;
   int          dn;
   int          nidle;

   fdiv_sequencer #(
      .CORE_LAT_D(18),
      .CORE_LAT_S(14)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .opa       (opa),
      .opb       (opb),
      .dbl       (dbl),
      .busy      (busy),
      .done      (done),
      .q_sign    (q_sign),
      .q_exp     (q_exp),
      .q_fq      (q_fq),
      .q_special (q_special),
      .q_nan     (q_nan),
      .q_inf     (q_inf),
      .q_zero    (q_zero),
      .q_invalid (q_invalid),
      .q_dbz     (q_dbz),
      .core_start(core_start),
      .core_fa   (core_fa),
      .core_fb   (core_fb),
      .core_db   (core_db),
      .core_fdiv (core_fdiv),
      .core_fq   (core_fq)
   );

   always #5 clk = ~clk;

   // Core model: quotient valid exactly lat_now cycles after the launch cycle.
   always @(posedge clk) begin
      if (core_start) since <= 1;
      else if (since > 0) since <= since + 1;
   end
   assign core_fq = (since == lat_now) ? fq_val : 57'h1_2345_6789_ABCD;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drives a request in the current cycle, which becomes cycle 0.
   task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic d,
                         input int lat, input logic [56:0] fq);
      opa     = a;
      opb     = b;
      dbl     = d;
      lat_now = lat;
      fq_val  = fq;
      start   = 1'b1;
      cyc     = 0;
   endtask

   // Steps up to maxc cycles, stopping at done; mask[n] drives start in cycle n.
   task automatic watch(input int maxc, input logic [63:0] mask, output int cs_cyc,
                        output int n_cs, output int dn_cyc, output int n_idle);
      cs_cyc = -1;
      n_cs   = 0;
      dn_cyc = -1;
      n_idle = 0;
      for (int k = 0; k < maxc; k++) begin
         next_cycle();
         start = (cyc < 64) ? mask[cyc[5:0]] : 1'b0;
         if (core_start) begin
            n_cs++;
            cs_cyc = cyc;
         end
         if (!busy) n_idle++;
         if (done) begin
            dn_cyc = cyc;
            break;
         end
      end
   endtask

   initial begin
      start = 1'b0;
      opa   = '0;
      opb   = '0;
      dbl   = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_outputs", 64'(|{busy, done, q_sign, q_exp, q_fq, q_special, q_nan, q_inf,
                                 q_zero, q_invalid, q_dbz, core_start, core_fa, core_fb,
                                 core_db, core_fdiv}), 64'd0);
      next_cycle();
      rst_n = 1'b1;

      // Double 1.0 / 1.0
      next_cycle();
      launch(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 18, 57'h80_0000_0000_0000);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("d11_start_cyc", 64'(cs), 64'd2);
      chk("d11_start_cnt", 64'(ncs), 64'd1);
      chk("d11_done_cyc", 64'(dn), 64'd21);
      chk("d11_busy_gap", 64'(nidle), 64'd0);
      chk("d11_fa", 64'(core_fa), 64'h10_0000_0000_0000);
      chk("d11_fb", 64'(core_fb), 64'h10_0000_0000_0000);
      chk("d11_db", 64'(core_db), 64'd1);
      chk("d11_exp", 64'(q_exp), 64'd1023);
      chk("d11_sign", 64'(q_sign), 64'd0);
      chk("d11_fq", 64'(q_fq), 64'h80_0000_0000_0000);
      chk("d11_special", 64'(q_special), 64'd0);
      next_cycle();
      chk("d11_done_once", 64'(done), 64'd0);
      chk("d11_idle", 64'(busy), 64'd0);

      // Single 1.5 / -2.0
      launch(64'h3FC0_0000, 64'hC000_0000, 1'b0, 14, 57'h60_0000_0000_0000);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("s15_start_cyc", 64'(cs), 64'd2);
      chk("s15_done_cyc", 64'(dn), 64'd17);
      chk("s15_fa", 64'(core_fa), 64'h18_0000_0000_0000);
      chk("s15_fb", 64'(core_fb), 64'h10_0000_0000_0000);
      chk("s15_db", 64'(core_db), 64'd0);
      chk("s15_exp", 64'(q_exp), 64'd126);
      chk("s15_sign", 64'(q_sign), 64'd1);
      chk("s15_fq", 64'(q_fq), 64'h60_0000_0000_0000);

      // Double 6.0 / +0.0
      next_cycle();
      launch(64'h4018_0000_0000_0000, 64'd0, 1'b1, 18, 57'd0);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("dbz_done_cyc", 64'(dn), 64'd2);
      chk("dbz_no_core", 64'(ncs), 64'd0);
      chk("dbz_flags", 64'({q_special, q_nan, q_inf, q_zero, q_invalid, q_dbz}), 64'b101001);
      chk("dbz_fq", 64'(q_fq), 64'd0);
      chk("dbz_exp", 64'(q_exp), 64'd0);
      chk("dbz_sign", 64'(q_sign), 64'd0);

      // Double -0 / +0
      next_cycle();
      launch(64'h8000_0000_0000_0000, 64'd0, 1'b1, 18, 57'd0);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("zz_done_cyc", 64'(dn), 64'd2);
      chk("zz_flags", 64'({q_special, q_nan, q_inf, q_zero, q_invalid, q_dbz}), 64'b110010);
      chk("zz_sign", 64'(q_sign), 64'd0);

      // Single 1.0 / -inf
      next_cycle();
      launch(64'h3F80_0000, 64'hFF80_0000, 1'b0, 14, 57'd0);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("finf_done_cyc", 64'(dn), 64'd2);
      chk("finf_flags", 64'({q_special, q_nan, q_inf, q_zero, q_invalid, q_dbz}), 64'b100100);
      chk("finf_sign", 64'(q_sign), 64'd1);

      // Double +inf / 2.0
      next_cycle();
      launch(64'h7FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 18, 57'd0);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("inff_flags", 64'({q_special, q_nan, q_inf, q_zero, q_invalid, q_dbz}), 64'b101000);
      chk("inff_no_core", 64'(ncs), 64'd0);

      // Double NaN / 1.0
      next_cycle();
      launch(64'hFFF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 18, 57'd0);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("nan_flags", 64'({q_special, q_nan, q_inf, q_zero, q_invalid, q_dbz}), 64'b110000);
      chk("nan_sign", 64'(q_sign), 64'd0);

      // Double 1.0 / smallest denormal
      next_cycle();
      launch(64'h3FF0_0000_0000_0000, 64'd1, 1'b1, 18, 57'd1);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("den_done_cyc", 64'(dn), 64'd21);
      chk("den_fa", 64'(core_fa), 64'h10_0000_0000_0000);
      chk("den_fb", 64'(core_fb), 64'h10_0000_0000_0000);
      chk("den_exp", 64'(q_exp), 64'd2097);
      chk("den_special", 64'(q_special), 64'd0);
      chk("den_fq", 64'(q_fq), 64'd1);

      // Single denormal dividend 2^-127 / 1.0
      next_cycle();
      launch(64'h0040_0000, 64'h3F80_0000, 1'b0, 14, 57'h7);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("sden_done_cyc", 64'(dn), 64'd17);
      chk("sden_fa", 64'(core_fa), 64'h10_0000_0000_0000);
      chk("sden_exp", 64'(q_exp), 64'd0);
      chk("sden_fq", 64'(q_fq), 64'h7);

      // start re-pulsed in cycles 1, 5 and in the DONE cycle
      next_cycle();
      launch(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 18, 57'h80_0000_0000_0000);
      watch(40, 64'h0000_0000_0020_0022, cs, ncs, dn, nidle);
      chk("rep_start_cnt", 64'(ncs), 64'd1);
      chk("rep_done_cyc", 64'(dn), 64'd21);
      chk("rep_busy_gap", 64'(nidle), 64'd0);
      next_cycle();
      chk("rep_idle_busy", 64'(busy), 64'd0);
      chk("rep_idle_done", 64'(done), 64'd0);
      launch(64'h3FC0_0000, 64'hC000_0000, 1'b0, 14, 57'h60_0000_0000_0000);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("rep_next_done_cyc", 64'(dn), 64'd17);
      chk("rep_next_exp", 64'(q_exp), 64'd126);

      // Reset at cycle 10 of a double op
      next_cycle();
      launch(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 18, 57'h80_0000_0000_0000);
      watch(10, 64'd0, cs, ncs, dn, nidle);
      chk("abort_pre_done", 64'(dn), -64'sd1);
      chk("abort_pre_fdiv", 64'(core_fdiv), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", 64'(|{busy, done, q_sign, q_exp, q_fq, q_special, q_nan, q_inf,
                                 q_zero, q_invalid, q_dbz, core_start, core_fa, core_fb,
                                 core_db, core_fdiv}), 64'd0);
      watch(3, 64'd0, cs, ncs, dn, nidle);
      chk("abort_no_done", 64'(dn), -64'sd1);
      rst_n = 1'b1;
      next_cycle();
      launch(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 18, 57'h80_0000_0000_0000);
      watch(40, 64'd0, cs, ncs, dn, nidle);
      chk("post_rst_done_cyc", 64'(dn), 64'd21);
      chk("post_rst_fq", 64'(q_fq), 64'h80_0000_0000_0000);
      chk("post_rst_exp", 64'(q_exp), 64'd1023);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
